// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO on its own 4 KB MMIO page.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_4000,
  parameter int          BAUD_DIV   = 434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_size,
  output logic [31:0] o_rdata,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Access size and upper write-data bits carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{i_size, i_wdata[31:8]};

  // Address decode
  logic        page_hit;
  logic [11:0] off;
  logic        wr_data, wr_ctrl, fifo_clr;
  assign page_hit = (i_addr & 32'hFFFF_F000) == BASE_ADDR;
  assign off      = i_addr[11:0];
  assign wr_data  = i_we && page_hit && (off == 12'h000);
  assign wr_ctrl  = i_we && page_hit && (off == 12'h008);
  assign fifo_clr = wr_ctrl && i_wdata[1];

  // FIFO state
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          fifo_full, fifo_empty, do_push, pop;
  assign fifo_full  = count_q == CW'(FIFO_DEPTH);
  assign fifo_empty = count_q == '0;
  // Clear wins over a concurrent push; a push into a full FIFO is dropped.
  assign do_push    = wr_data && !fifo_full && !fifo_clr;

  // Control / sticky status
  logic enable_q, ovf_q;

  // FSM state
  state_t        state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d, bit_end;
  assign bit_end = cnt_q == BW'(BAUD_DIV - 1);

  // FIFO storage write (data only, no reset needed)
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_wdata[7:0];
  end

  // FIFO pointers and occupancy; clear drops queued bytes, not the frame in flight
  always_ff @(posedge i_clk) begin
    if (!i_rstn || fifo_clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !pop)      count_q <= count_q + CW'(1);
      else if (!do_push && pop) count_q <= count_q - CW'(1);
    end
  end

  // CTRL enable and sticky overflow flag
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      enable_q <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable_q <= i_wdata[0];
        if (i_wdata[2]) ovf_q <= 1'b0;
      end
      if (wr_data && fifo_full && !fifo_clr) ovf_q <= 1'b1;
    end
  end

  // Serialiser state register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Serialiser next state; o_tx is registered so levels are set on transitions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (enable_q && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = S_START;
          tx_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          cnt_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Combinational read mux, no side effects
  always_comb begin
    o_rdata = '0;
    if (page_hit) begin
      case (off)
        12'h004: o_rdata = {19'd0, 5'(count_q), 4'd0, ovf_q, fifo_empty, fifo_full,
                            state_q != S_IDLE};
        12'h008: o_rdata = {31'd0, enable_q};
        default: o_rdata = '0;
      endcase
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = (state_q != S_IDLE) || !fifo_empty;

endmodule
